// File: rtl/alu_seq.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith/compare ops plus iterative
// signed/unsigned multiply and divide producing HI/LO, with valid/ready handshakes.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_NOR   = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SLTU  = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011
    } op_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic              zero_q, zero_d;
    logic              overflow_q, overflow_d;
    logic              div_zero_q, div_zero_d;
    logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;

    op_t               op;
    logic              signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]  in0_mag, in1_mag, add_res, sub_res;
    logic              add_ovf, sub_ovf;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  mul_hi_nx, mul_lo_nx;
    logic [2*WIDTH-1:0] mul_prod, mul_fin;

    logic [WIDTH:0]    div_sh, div_diff;
    logic              div_ok;
    logic [WIDTH-1:0]  div_rem_nx, div_quo_nx, div_rem_fin, div_quo_fin;

    assign op        = op_t'(alu_op);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = signed_op & in0[WIDTH-1];
    assign b_neg     = signed_op & in1[WIDTH-1];
    assign in0_mag   = a_neg ? -in0 : in0;
    assign in1_mag   = b_neg ? -in1 : in1;

    assign add_res = in0 + in1;
    assign sub_res = in0 - in1;
    assign add_ovf = (in0[WIDTH-1] == in1[WIDTH-1]) && (add_res[WIDTH-1] != in0[WIDTH-1]);
    assign sub_ovf = (in0[WIDTH-1] != in1[WIDTH-1]) && (sub_res[WIDTH-1] != in0[WIDTH-1]);

    // Shift-add step: {acc_hi, acc_lo} holds partial product over the shifting multiplier.
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    assign mul_prod  = {mul_hi_nx, mul_lo_nx};
    assign mul_fin   = neg_lo_q ? -mul_prod : mul_prod;

    // Restoring step: dividend bits shift out of acc_lo as quotient bits shift in.
    assign div_sh      = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff    = div_sh - {1'b0, opb_q};
    assign div_ok      = ~div_diff[WIDTH];
    assign div_rem_nx  = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_quo_nx  = {acc_lo_q[WIDTH-2:0], div_ok};
    assign div_quo_fin = neg_lo_q ? -div_quo_nx : div_quo_nx;
    assign div_rem_fin = neg_hi_q ? -div_rem_nx : div_rem_nx;

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        hi_d       = hi_q;
        overflow_d = overflow_q;
        div_zero_d = div_zero_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opb_d      = opb_q;
        cnt_d      = cnt_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d    = DONE;
                hi_d       = '0;
                overflow_d = 1'b0;
                div_zero_d = 1'b0;
                case (op)
                    OP_AND:  result_d = in0 & in1;
                    OP_OR:   result_d = in0 | in1;
                    OP_NOR:  result_d = ~(in0 | in1);
                    OP_XOR:  result_d = in0 ^ in1;
                    OP_ADD:  begin result_d = add_res; overflow_d = add_ovf; end
                    OP_SUB:  begin result_d = sub_res; overflow_d = sub_ovf; end
                    OP_SLT:  result_d = WIDTH'($signed(in0) < $signed(in1));
                    OP_SLTU: result_d = WIDTH'(in0 < in1);
                    OP_MULT, OP_MULTU: begin
                        state_d  = MUL;
                        acc_hi_d = '0;
                        acc_lo_d = in1_mag;
                        opb_d    = in0_mag;
                        cnt_d    = '0;
                        neg_lo_d = a_neg ^ b_neg;
                    end
                    OP_DIV, OP_DIVU: begin
                        if (in1 == '0) begin
                            result_d   = '1;
                            hi_d       = in0;
                            div_zero_d = 1'b1;
                        end else begin
                            state_d  = DIV;
                            acc_hi_d = '0;
                            acc_lo_d = in0_mag;
                            opb_d    = in1_mag;
                            cnt_d    = '0;
                            neg_lo_d = a_neg ^ b_neg;
                            neg_hi_d = a_neg;
                        end
                    end
                    default: result_d = '0;
                endcase
            end
            // The last iteration edge also applies sign correction and commits the result.
            MUL: begin
                acc_hi_d = mul_hi_nx;
                acc_lo_d = mul_lo_nx;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    {hi_d, result_d} = mul_fin;
                    state_d          = DONE;
                end
            end
            DIV: begin
                acc_hi_d = div_rem_nx;
                acc_lo_d = div_quo_nx;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    result_d = div_quo_fin;
                    hi_d     = div_rem_fin;
                    state_d  = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        zero_d      = (result_d == '0);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b1;
            overflow_q  <= 1'b0;
            div_zero_q  <= 1'b0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opb_q       <= '0;
            cnt_q       <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            div_zero_q  <= div_zero_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opb_q       <= opb_d;
            cnt_q       <= cnt_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
        end
    end

    assign in_ready  = reset_n & (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign div_zero  = div_zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero, overflow, div_zero;
    logic [3:0]  alu_op;
    logic [31:0] in0, in1, result, hi;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, overflow8, div_zero8;
    logic [3:0]  alu_op8;
    logic [7:0]  in0_8, in1_8, result8, hi8;

    int checks = 0;
    int failures = 0;
    int lat;
    int bad;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .in0(in0), .in1(in1), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .hi(hi), .zero(zero), .overflow(overflow), .div_zero(div_zero)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .alu_op(alu_op8), .in0(in0_8), .in1(in1_8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .hi(hi8), .zero(zero8), .overflow(overflow8), .div_zero(div_zero8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one op at a negedge, scrambles inputs after accept, measures cycles to out_valid.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        chk("in_ready_before_issue", 64'(in_ready), 64'd1);
        in_valid = 1'b1; alu_op = op; in0 = a; in1 = b;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; alu_op = 4'hF; in0 = $urandom; in1 = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_take", 64'(out_valid), 64'd0);
        chk("in_ready_after_take", 64'(in_ready), 64'd1);
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid8 = 1'b1; alu_op8 = op; in0_8 = a; in1_8 = b;
        @(posedge clk); @(negedge clk);
        in_valid8 = 1'b0; alu_op8 = 4'hF; in0_8 = 8'($urandom); in1_8 = 8'($urandom);
        lat = 1;
        while (out_valid8 !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    endtask

    task automatic release8();
        out_ready8 = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready8 = 1'b0;
        chk("w8_out_valid_after_take", 64'(out_valid8), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; alu_op = 4'h0; in0 = '0; in1 = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; alu_op8 = 4'h0; in0_8 = '0; in1_8 = '0;
        @(negedge clk); @(negedge clk);
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_flags", {62'd0, overflow, div_zero}, 64'd0);

        // Reset 5 cycles into a MULT: nothing may come out.
        in_valid = 1'b1; alu_op = 4'b1000; in0 = 32'hFFFF_FFFD; in1 = 32'd7;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("abort_in_ready_low", 64'(in_ready), 64'd0);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        chk("abort_no_out_valid", 64'(bad), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_zero", 64'(zero), 64'd1);
        chk("abort_in_ready", 64'(in_ready), 64'd1);

        issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
        chk("add_lat", 64'(lat), 64'd1);
        chk("add_result", 64'(result), 64'h8000_0000);
        chk("add_ovf", 64'(overflow), 64'd1);
        chk("add_zero", 64'(zero), 64'd0);
        chk("add_hi", 64'(hi), 64'd0);
        release_out();

        issue(4'b0110, 32'd64, 32'd64);
        chk("sub_result", 64'(result), 64'd0);
        chk("sub_zero", 64'(zero), 64'd1);
        chk("sub_ovf", 64'(overflow), 64'd0);
        release_out();

        issue(4'b0110, 32'h8000_0000, 32'd1);
        chk("sub_ovf_result", 64'(result), 64'h7FFF_FFFF);
        chk("sub_ovf_flag", 64'(overflow), 64'd1);
        release_out();

        issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("and_result", 64'(result), 64'h00F0_1200);
        release_out();
        issue(4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("or_result", 64'(result), 64'hFFF0_FF34);
        release_out();
        issue(4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("nor_result", 64'(result), 64'h000F_00CB);
        release_out();
        issue(4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("xor_result", 64'(result), 64'hFF00_ED34);
        release_out();

        issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
        chk("slt_result", 64'(result), 64'd1);
        chk("slt_zero", 64'(zero), 64'd0);
        release_out();
        issue(4'b0101, 32'hFFFF_FFFF, 32'd1);
        chk("sltu_result", 64'(result), 64'd0);
        chk("sltu_zero", 64'(zero), 64'd1);
        release_out();
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("undef_result", 64'(result), 64'd0);
        chk("undef_hi", 64'(hi), 64'd0);
        chk("undef_zero", 64'(zero), 64'd1);
        release_out();

        issue(4'b1000, 32'hFFFF_FFFD, 32'd7);
        chk("mult_lat", 64'(lat), 64'd33);
        chk("mult_prod", {hi, result}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mult_zero", 64'(zero), 64'd0);
        release_out();
        issue(4'b1001, 32'hFFFF_FFFF, 32'd2);
        chk("multu_prod", {hi, result}, 64'h0000_0001_FFFF_FFFE);
        release_out();

        issue(4'b1010, 32'hFFFF_FFF9, 32'd2);
        chk("div_lat", 64'(lat), 64'd33);
        chk("div_quot", 64'(result), 64'hFFFF_FFFD);
        chk("div_rem", 64'(hi), 64'hFFFF_FFFF);
        release_out();
        issue(4'b1011, 32'd400, 32'd300);
        chk("divu_quot", 64'(result), 64'd1);
        chk("divu_rem", 64'(hi), 64'd100);
        release_out();
        issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_minneg_quot", 64'(result), 64'h8000_0000);
        chk("div_minneg_rem", 64'(hi), 64'd0);
        chk("div_minneg_flags", {62'd0, overflow, div_zero}, 64'd0);
        release_out();
        issue(4'b1010, 32'd5, 32'd0);
        chk("div0_lat", 64'(lat), 64'd1);
        chk("div0_result", 64'(result), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(hi), 64'd5);
        chk("div0_flag", 64'(div_zero), 64'd1);
        release_out();

        // Backpressure: result must hold and new requests must be dropped.
        issue(4'b0010, 32'd3, 32'd4);
        in_valid = 1'b1; alu_op = 4'b0000; in0 = '0; in1 = '0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd7 || zero !== 1'b0) bad++;
        end
        chk("bp_stable", 64'(bad), 64'd0);
        in_valid = 1'b0;
        release_out();
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        chk("bp_not_queued", 64'(bad), 64'd0);

        issue8(4'b1000, 8'hFD, 8'd7);
        chk("w8_mult_lat", 64'(lat), 64'd9);
        chk("w8_mult_prod", 64'({hi8, result8}), 64'hFFEB);
        release8();
        issue8(4'b1010, 8'hF9, 8'd2);
        chk("w8_div_lat", 64'(lat), 64'd9);
        chk("w8_div_quot", 64'(result8), 64'hFD);
        chk("w8_div_rem", 64'(hi8), 64'hFF);
        release8();
        issue8(4'b1010, 8'h80, 8'hFF);
        chk("w8_div_minneg", 64'({hi8, result8}), 64'h0080);
        release8();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
